// File: rtl/key_pulse_conditioner.sv
// ----------------------------------------------------------------------------
// key_pulse_conditioner
//
// Input stage for the tug-of-war playfield. Conditions the two raw board
// pushbuttons into clean one-clock step pulses for the light cells.
// Each button goes through a 2-flop synchronizer and a debounce FSM, and
// gives one pulse per physical press. Holding a button therefore advances
// the game by exactly one step.
//
// Ports:
//   clk      system clock
//   reset    synchronous, active-high reset
//   key_l_n  raw left button (KEY[3]), active-low, asynchronous
//   key_r_n  raw right button (KEY[0]), active-low, asynchronous
//   freeze   suppresses pulses (game over). The debounce FSMs keep tracking.
//   L        one-cycle pulse per accepted left press
//   R        one-cycle pulse per accepted right press
//   l_held   debounced left level (1 = pressed)
//   r_held   debounced right level (1 = pressed)
// ----------------------------------------------------------------------------

// One debounce channel: synchronizer, debounce FSM, and registered outputs.
//
// Ports:
//   clk, reset  as in the top level
//   key_n       raw active-low button
//   freeze      drop the press pulse when high
//   pulse       one-cycle pulse per accepted press
//   held        debounced level (1 = pressed)
module key_pulse_channel #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic key_n,
    input  logic freeze,
    output logic pulse,
    output logic held
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);

    typedef enum logic [1:0] {
        IDLE,
        PRESS_WAIT,
        HELD,
        RELEASE_WAIT
    } state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic          sync1;
    logic          sync2;
    logic          pressed;

    // Only the second synchronizer flop is safe to look at.
    assign pressed = ~sync2;

    // NOTE: every register here uses non-blocking assignments, so all of them
    // see the values from before the edge. sync2 gets the old sync1, and the
    // FSM sees the old sync2.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
            state <= IDLE;
            cnt   <= '0;
            pulse <= 1'b0;
            held  <= 1'b0;
        end else begin
            sync1 <= key_n;
            sync2 <= sync1;
            pulse <= 1'b0;

            case (state)
                IDLE: begin
                    if (pressed) begin
                        state <= PRESS_WAIT;
                        cnt   <= CNT_ONE;
                    end
                end

                PRESS_WAIT: begin
                    if (!pressed) begin
                        state <= IDLE;
                        cnt   <= '0;
                    end else if (cnt == CNT_MAX) begin
                        // The press is accepted even under freeze. Only the
                        // pulse is dropped, so it can never be emitted later.
                        state <= HELD;
                        cnt   <= '0;
                        held  <= 1'b1;
                        pulse <= ~freeze;
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end

                HELD: begin
                    if (!pressed) begin
                        state <= RELEASE_WAIT;
                        cnt   <= CNT_ONE;
                    end
                end

                RELEASE_WAIT: begin
                    // A bounce back to pressed returns to HELD without a new
                    // pulse.
                    if (pressed) begin
                        state <= HELD;
                        cnt   <= '0;
                    end else if (cnt == CNT_MAX) begin
                        state <= IDLE;
                        cnt   <= '0;
                        held  <= 1'b0;
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end

                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                    held  <= 1'b0;
                end
            endcase
        end
    end

endmodule

module key_pulse_conditioner #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic key_l_n,
    input  logic key_r_n,
    input  logic freeze,
    output logic L,
    output logic R,
    output logic l_held,
    output logic r_held
);

    // The two channels are fully independent. There is no arbitration,
    // because the light cells resolve a simultaneous L and R themselves.
    key_pulse_channel #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_left (
        .clk    (clk),
        .reset  (reset),
        .key_n  (key_l_n),
        .freeze (freeze),
        .pulse  (L),
        .held   (l_held)
    );

    key_pulse_channel #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_right (
        .clk    (clk),
        .reset  (reset),
        .key_n  (key_r_n),
        .freeze (freeze),
        .pulse  (R),
        .held   (r_held)
    );

endmodule
